// File: rtl/bus8088_pkg.sv
// Shared types and constants for the 8088 minimum-mode bus-cycle initiator.
package bus8088_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    TW   = 3'd4,
    T4   = 3'd5
  } bus_state_e;

  typedef struct packed {
    logic        write;
    logic        io;
    logic [19:0] addr;
    logic [7:0]  wdata;
  } bus_cmd_t;

  localparam logic [19:0] IO_ADDR_MASK = 20'h0FFFF;

endpackage

// File: rtl/bus8088_master.sv
// 8088 minimum-mode bus master: turns single-byte requests into T1..T4 cycles
// with READY-driven wait states and an optional wait-state timeout.
module bus8088_master
  import bus8088_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic        READY,
  inout  wire  [7:0]  AD,
  output logic [11:0] A,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        IOM,
  output logic        DTR,
  output logic        DEN
);

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  bus_state_e    r_state, w_state_next;
  bus_cmd_t      r_cmd, w_cmd_next, w_req_cmd;
  logic [CW-1:0] r_wcnt, w_wcnt_next;
  logic [CW:0]   w_wcnt_inc;
  logic          w_accept, w_limit_hit, w_timeout, w_capture, w_data_phase;

  logic          r_ale, r_rd, r_wr, r_den, r_dtr, r_iom;
  logic [11:0]   r_a;
  logic          r_ad_oe;
  logic [7:0]    r_ad_out;
  logic          r_req_ready, r_rsp_valid, r_rsp_err;
  logic [7:0]    r_rsp_rdata;

  assign w_accept   = req_valid & r_req_ready;
  assign w_wcnt_inc = {1'b0, r_wcnt} + {{CW{1'b0}}, 1'b1};
  // w_wcnt_inc is the ordinal of the TW cycle in progress.
  assign w_limit_hit = (WAIT_LIMIT != 0) && (w_wcnt_inc >= (CW+1)'(WAIT_LIMIT));

  always_comb begin
    w_req_cmd.write = req_write;
    w_req_cmd.io    = req_io;
    w_req_cmd.addr  = req_io ? (req_addr & IO_ADDR_MASK) : req_addr;
    w_req_cmd.wdata = req_wdata;
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_next   = r_cmd;
    w_wcnt_next  = r_wcnt;
    w_timeout    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = T1;
          w_cmd_next   = w_req_cmd;
        end
      end
      T1: begin
        w_state_next = T2;
        w_wcnt_next  = '0;
      end
      T2: w_state_next = T3;
      T3: begin
        if (READY) begin
          w_state_next = T4;
          w_capture    = ~r_cmd.write;
        end else begin
          w_state_next = TW;
        end
      end
      TW: begin
        if (r_wcnt != {CW{1'b1}}) w_wcnt_next = w_wcnt_inc[CW-1:0];
        if (READY) begin
          w_state_next = T4;
          w_capture    = ~r_cmd.write;
        end else if (w_limit_hit) begin
          w_state_next = T4;
          w_timeout    = 1'b1;
        end
      end
      T4: begin
        if (w_accept) begin
          w_state_next = T1;
          w_cmd_next   = w_req_cmd;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_data_phase = (w_state_next == T2) || (w_state_next == T3) || (w_state_next == TW);

  // Every bus output is registered from the next state so it lines up with the state it belongs to.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_wcnt      <= '0;
      r_ale       <= 1'b0;
      r_rd        <= 1'b1;
      r_wr        <= 1'b1;
      r_den       <= 1'b1;
      r_dtr       <= 1'b1;
      r_iom       <= 1'b0;
      r_a         <= '0;
      r_ad_oe     <= 1'b0;
      r_ad_out    <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 8'hFF;
    end else begin
      r_state     <= w_state_next;
      r_cmd       <= w_cmd_next;
      r_wcnt      <= w_wcnt_next;
      r_ale       <= (w_state_next == T1);
      r_rd        <= ~(w_data_phase & ~w_cmd_next.write);
      r_wr        <= ~(w_data_phase & w_cmd_next.write);
      r_den       <= ~w_data_phase;
      r_req_ready <= (w_state_next == IDLE) || (w_state_next == T4);
      r_rsp_valid <= (w_state_next == T4);
      r_rsp_err   <= w_timeout;
      if (w_state_next == T1) begin
        r_iom <= w_cmd_next.io;
        r_dtr <= w_cmd_next.write;
        r_a   <= w_cmd_next.addr[19:8];
      end
      // Write data stays on AD through T4 as the write hold.
      r_ad_oe  <= (w_state_next == T1) ||
                  (w_cmd_next.write && (w_data_phase || (w_state_next == T4)));
      r_ad_out <= (w_state_next == T1) ? w_cmd_next.addr[7:0] : w_cmd_next.wdata;
      if (w_state_next == T4 && r_state != T4)
        r_rsp_rdata <= w_capture ? AD : 8'hFF;
    end
  end

  assign AD        = r_ad_oe ? r_ad_out : 8'hzz;
  assign A         = r_a;
  assign ALE       = r_ale;
  assign RD        = r_rd;
  assign WR        = r_wr;
  assign DEN       = r_den;
  assign DTR       = r_dtr;
  assign IOM       = r_iom;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_bus8088_master.sv
// Directed bench for bus8088_master with a small 8088-style device model on the bus.
module tb_bus8088_master;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_io = 1'b0;
  logic [19:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        READY = 1'b1;
  wire  [7:0]  AD;
  logic [11:0] A;
  logic        ALE, RD, WR, IOM, DTR, DEN;

  logic [7:0]  dev_rdata = 8'h00;
  logic [7:0]  dev_wdata = 8'h00;
  logic [19:0] dev_waddr = '0;

  int n_cmp = 0;
  int n_bad = 0;

  bus8088_master #(.WAIT_LIMIT(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .READY(READY), .AD(AD), .A(A), .ALE(ALE), .RD(RD), .WR(WR),
    .IOM(IOM), .DTR(DTR), .DEN(DEN)
  );

  always #5 CLK = ~CLK;

  // Released bus floats high; device answers reads while RD is low.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
      pullup pu (AD[gi]);
    end
  endgenerate
  assign AD = (!RD) ? dev_rdata : 8'hzz;

  always @(posedge CLK) begin
    if (ALE) dev_waddr <= {A, AD};
    if (!WR && READY) dev_wdata <= AD;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        io;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  dev;
    int          nlow;
    logic [11:0] exp_a;
    logic [7:0]  exp_adlo;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic run_txn(input vec_t v);
    int lat;
    lat = 0;
    @(negedge CLK);
    check("req_ready_before", {31'b0, req_ready}, 1);
    req_write = v.wr; req_io = v.io; req_addr = v.addr; req_wdata = v.wdata;
    dev_rdata = v.dev; READY = 1'b1; req_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    check("t1_ale", {31'b0, ALE}, 1);
    check("t1_ad", {24'b0, AD}, {24'b0, v.exp_adlo});
    check("t1_a", {20'b0, A}, {20'b0, v.exp_a});
    check("t1_iom", {31'b0, IOM}, {31'b0, v.io});
    check("t1_dtr", {31'b0, DTR}, {31'b0, v.wr});
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 2) begin
        check("t2_rd", {31'b0, RD}, {31'b0, v.wr});
        check("t2_wr", {31'b0, WR}, {31'b0, ~v.wr});
        check("t2_den", {31'b0, DEN}, 0);
        check("t2_ale", {31'b0, ALE}, 0);
        if (v.wr) check("t2_ad", {24'b0, AD}, {24'b0, v.wdata});
      end
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      READY = !(cyc >= 3 && cyc < 3 + v.nlow);
      @(negedge CLK);
    end
    check("latency", lat, v.exp_lat);
    check("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, v.exp_rdata});
    check("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
    check("t4_strobes", {29'b0, RD, WR, DEN}, 7);
    $display("txn wr=%0d io=%0d addr=%05h lat=%0d rdata=%02h err=%0d", v.wr, v.io, v.addr, lat, rsp_rdata, rsp_err);
    @(negedge CLK);
    READY = 1'b1;
    check("idle_rsp_valid", {31'b0, rsp_valid}, 0);
    check("idle_ad_released", {24'b0, AD}, 32'hFF);
    if (v.wr && !v.exp_err) begin
      check("dev_wdata", {24'b0, dev_wdata}, {24'b0, v.wdata});
      check("dev_waddr", {12'b0, dev_waddr}, {12'b0, v.exp_a, v.exp_adlo});
    end
  endtask

  initial begin
    int first, second, seen;
    vecs[0] = '{1'b0, 1'b0, 20'h80010, 8'h00, 8'hA5, 0,  12'h800, 8'h10, 8'hA5, 1'b0, 4};
    vecs[1] = '{1'b1, 1'b1, 20'h0FF0F, 8'h3C, 8'h00, 0,  12'h0FF, 8'h0F, 8'hFF, 1'b0, 4};
    vecs[2] = '{1'b0, 1'b0, 20'h12345, 8'h00, 8'h5A, 3,  12'h123, 8'h45, 8'h5A, 1'b0, 7};
    vecs[3] = '{1'b0, 1'b0, 20'h0ABCD, 8'h00, 8'h77, 99, 12'h0AB, 8'hCD, 8'hFF, 1'b1, 8};
    vecs[4] = '{1'b0, 1'b0, 20'h40000, 8'h00, 8'h66, 4,  12'h400, 8'h00, 8'h66, 1'b0, 8};
    vecs[5] = '{1'b0, 1'b1, 20'hF1234, 8'h00, 8'h0C, 0,  12'h012, 8'h34, 8'h0C, 1'b0, 4};
    vecs[6] = '{1'b1, 1'b0, 20'h3FFFF, 8'h81, 8'h00, 2,  12'h3FF, 8'hFF, 8'hFF, 1'b0, 6};

    #12;
    check("rst_ctrl", {26'b0, ALE, RD, WR, DEN, DTR, IOM}, 6'b011110);
    check("rst_a", {20'b0, A}, 0);
    check("rst_ad", {24'b0, AD}, 32'hFF);
    check("rst_handshake", {29'b0, req_ready, rsp_valid, rsp_err}, 0);
    check("rst_rdata", {24'b0, rsp_rdata}, 32'hFF);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1 check("ready_before_edge", {31'b0, req_ready}, 0);
    @(negedge CLK);
    check("ready_after_release", {31'b0, req_ready}, 1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Back-to-back write then read with req_valid held high.
    @(negedge CLK);
    req_write = 1'b1; req_io = 1'b0; req_addr = 20'h01000; req_wdata = 8'h99;
    READY = 1'b1; req_valid = 1'b1;
    @(posedge CLK);
    first = 0; second = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge CLK);
      if (first == 0 && rsp_valid) begin
        first = cyc;
        check("b2b_ready_t4", {31'b0, req_ready}, 1);
        req_write = 1'b0; req_addr = 20'h01001; dev_rdata = 8'h42;
      end else if (first != 0 && cyc == first + 1) begin
        check("b2b_t1_follows_t4", {31'b0, ALE}, 1);
        check("b2b_t1_ad", {24'b0, AD}, 32'h01);
        req_valid = 1'b0;
      end else if (first != 0 && rsp_valid) begin
        second = cyc;
        break;
      end
    end
    check("b2b_first_lat", first, 4);
    check("b2b_spacing", second - first, 4);
    check("b2b_rdata", {24'b0, rsp_rdata}, 32'h42);
    check("b2b_dev_wdata", {24'b0, dev_wdata}, 32'h99);
    $display("txn back-to-back write/read first=%0d second=%0d rdata=%02h", first, second, rsp_rdata);

    // Reset pulse during T3 of a read.
    @(negedge CLK);
    req_write = 1'b0; req_io = 1'b0; req_addr = 20'h00200; dev_rdata = 8'h11; req_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("pre_rst_t3_rd", {31'b0, RD}, 0);
    #1 RESET_N = 1'b0;
    #1;
    check("mid_rst_ctrl", {26'b0, ALE, RD, WR, DEN, DTR, IOM}, 6'b011110);
    check("mid_rst_ad", {24'b0, AD}, 32'hFF);
    check("mid_rst_hs", {29'b0, req_ready, rsp_valid, rsp_err}, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (rsp_valid) seen++;
    end
    check("mid_rst_no_rsp", seen, 0);
    $display("txn reset during T3: rsp_valid pulses after reset=%0d", seen);
    run_txn(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
